// File: rtl/rename_if.sv
// Rename-unit handshake bundle: decode-side rename requests, writeback
// strobes, commit strobes and flush, plus the renamed results.
interface rename_if #(
  parameter int XLEN   = 32,
  parameter int ROBLEN = 16,
  parameter int DW     = 2,
  parameter int CW     = 2,
  parameter int WBW    = 2
);
  localparam int PLEN  = XLEN + ROBLEN;
  localparam int XBITS = $clog2(XLEN);
  localparam int PBITS = $clog2(PLEN);

  logic                    i_dispatch;
  logic [2*DW*XBITS-1:0]   i_rs_arch;
  logic [2*DW*PBITS-1:0]   o_rs_phys;
  logic [2*DW-1:0]         o_rs_rdy;
  logic [DW-1:0]           i_rd_valid;
  logic [DW*XBITS-1:0]     i_rd_arch;
  logic [DW*PBITS-1:0]     o_rd_phys;
  logic [DW*PBITS-1:0]     o_rd_old;
  logic                    o_alloc_ready;
  logic [PBITS:0]          o_free_count;
  logic [WBW-1:0]          i_wb_valid;
  logic [WBW*PBITS-1:0]    i_wb_phys;
  logic [CW-1:0]           i_cmt_valid;
  logic [CW*XBITS-1:0]     i_cmt_arch;
  logic [CW*PBITS-1:0]     i_cmt_phys;
  logic [CW*PBITS-1:0]     i_cmt_old;
  logic                    i_flush;

  modport master (
    output i_dispatch, i_rs_arch, i_rd_valid, i_rd_arch, i_wb_valid, i_wb_phys,
           i_cmt_valid, i_cmt_arch, i_cmt_phys, i_cmt_old, i_flush,
    input  o_rs_phys, o_rs_rdy, o_rd_phys, o_rd_old, o_alloc_ready, o_free_count
  );

  modport slave (
    input  i_dispatch, i_rs_arch, i_rd_valid, i_rd_arch, i_wb_valid, i_wb_phys,
           i_cmt_valid, i_cmt_arch, i_cmt_phys, i_cmt_old, i_flush,
    output o_rs_phys, o_rs_rdy, o_rd_phys, o_rd_old, o_alloc_ready, o_free_count
  );
endinterface

// File: rtl/rename_unit.sv
// Multi-wide register rename: speculative and committed arch->phys maps,
// physical free list and per-phys ready bits. Flush restores committed state.
module rename_unit #(
  parameter int XLEN   = 32,
  parameter int ROBLEN = 16,
  parameter int DW     = 2,
  parameter int CW     = 2,
  parameter int WBW    = 2
) (
  input  logic     i_clk,
  input  logic     i_rst_n,
  rename_if.slave  bus
);
  localparam int PLEN  = XLEN + ROBLEN;
  localparam int XBITS = $clog2(XLEN);
  localparam int PBITS = $clog2(PLEN);
  localparam logic [PBITS:0] ONE_CNT = 1;

  typedef logic [XLEN-1:0][PBITS-1:0] map_t;
  typedef logic [PLEN-1:0]            pvec_t;

  function automatic map_t identity_map();
    map_t m;
    for (int i = 0; i < XLEN; i++) m[i] = PBITS'(i);
    return m;
  endfunction

  function automatic pvec_t reset_free();
    pvec_t f;
    for (int p = 0; p < PLEN; p++) f[p] = (p >= XLEN);
    return f;
  endfunction

  // Packed views of the flat bus fields
  logic [2*DW-1:0][XBITS-1:0] rs_arch;
  logic [DW-1:0][XBITS-1:0]   rd_arch;
  logic [WBW-1:0][PBITS-1:0]  wb_phys;
  logic [CW-1:0][XBITS-1:0]   cmt_arch;
  logic [CW-1:0][PBITS-1:0]   cmt_phys, cmt_old;
  logic [2*DW-1:0][PBITS-1:0] rs_phys;
  logic [2*DW-1:0]            rs_rdy;
  logic [DW-1:0][PBITS-1:0]   rd_phys, rd_old, new_phys;
  logic [DW-1:0]              need;

  assign rs_arch  = bus.i_rs_arch;
  assign rd_arch  = bus.i_rd_arch;
  assign wb_phys  = bus.i_wb_phys;
  assign cmt_arch = bus.i_cmt_arch;
  assign cmt_phys = bus.i_cmt_phys;
  assign cmt_old  = bus.i_cmt_old;

  map_t  map_q, map_d, cmt_q, cmt_d;
  pvec_t free_q, free_d, ready_q, ready_d, avail;
  logic [PBITS:0] free_count, n_need;
  logic alloc_ready, fire, found;

  // Free count and lowest-first allocation of one phys per real dest
  // NOTE: every comb output gets a default before any branch, otherwise a latch is inferred.
  always_comb begin
    free_count = '0;
    for (int p = 0; p < PLEN; p++) free_count = free_count + (PBITS+1)'(free_q[p]);
    avail    = free_q;
    need     = '0;
    new_phys = '0;
    n_need   = '0;
    found    = 1'b0;
    for (int k = 0; k < DW; k++) begin
      need[k] = bus.i_rd_valid[k] && (rd_arch[k] != '0);
      if (need[k]) begin
        n_need = n_need + ONE_CNT;
        found  = 1'b0;
        for (int p = 0; p < PLEN; p++) begin
          if (!found && avail[p]) begin
            new_phys[k] = PBITS'(p);
            avail[p]    = 1'b0;
            found       = 1'b1;
          end
        end
      end
    end
    alloc_ready = (free_count >= n_need) && !bus.i_flush;
    fire        = bus.i_dispatch && alloc_ready;
  end

  // Source/dest renaming with intra-group and writeback bypass
  always_comb begin
    rs_phys = '0;
    rs_rdy  = '0;
    rd_phys = '0;
    rd_old  = '0;
    for (int k = 0; k < DW; k++) begin
      if (need[k]) begin
        rd_phys[k] = new_phys[k];
        rd_old[k]  = map_q[rd_arch[k]];
        for (int j = 0; j < k; j++)
          if (need[j] && rd_arch[j] == rd_arch[k]) rd_old[k] = new_phys[j];
      end
    end
    for (int s = 0; s < 2*DW; s++) begin
      rs_phys[s] = map_q[rs_arch[s]];
      rs_rdy[s]  = ready_q[map_q[rs_arch[s]]];
      for (int j = 0; j < s/2; j++) begin
        if (need[j] && rd_arch[j] == rs_arch[s]) begin
          rs_phys[s] = new_phys[j];
          rs_rdy[s]  = 1'b0;
        end
      end
      for (int w = 0; w < WBW; w++)
        if (bus.i_wb_valid[w] && wb_phys[w] == rs_phys[s]) rs_rdy[s] = 1'b1;
      if (rs_phys[s] == '0) rs_rdy[s] = 1'b1;
    end
  end

  assign bus.o_rs_phys     = rs_phys;
  assign bus.o_rs_rdy      = rs_rdy;
  assign bus.o_rd_phys     = rd_phys;
  assign bus.o_rd_old      = rd_old;
  assign bus.o_alloc_ready = alloc_ready;
  assign bus.o_free_count  = free_count;

  // Next state: dispatch, writeback, commit, then flush overrides speculation
  always_comb begin
    map_d   = map_q;
    cmt_d   = cmt_q;
    free_d  = free_q;
    ready_d = ready_q;
    if (fire) begin
      for (int k = 0; k < DW; k++) begin
        if (need[k]) begin
          map_d[rd_arch[k]]   = new_phys[k];
          free_d[new_phys[k]] = 1'b0;
          ready_d[new_phys[k]] = 1'b0;
        end
      end
    end
    for (int w = 0; w < WBW; w++)
      if (bus.i_wb_valid[w] && wb_phys[w] != '0) ready_d[wb_phys[w]] = 1'b1;
    for (int c = 0; c < CW; c++) begin
      if (bus.i_cmt_valid[c]) begin
        cmt_d[cmt_arch[c]] = cmt_phys[c];
        if (cmt_old[c] != '0) free_d[cmt_old[c]] = 1'b1;
      end
    end
    if (bus.i_flush) begin
      map_d   = cmt_d;
      free_d  = '1;
      for (int i = 0; i < XLEN; i++) free_d[cmt_d[i]] = 1'b0;
      ready_d = '1;
    end
  end

  // State registers
  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  // NOTE: the map tables are reset because their identity contents are architectural state.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      map_q   <= identity_map();
      cmt_q   <= identity_map();
      free_q  <= reset_free();
      ready_q <= '1;
    end else begin
      map_q   <= map_d;
      cmt_q   <= cmt_d;
      free_q  <= free_d;
      ready_q <= ready_d;
    end
  end
endmodule

// File: tb/tb_rename_unit.sv
// Self-checking bench for rename_unit: expectations are queued when stimulus
// is applied and compared against the combinational outputs mid-cycle.
module tb_rename_unit;
  localparam int XLEN  = 32;
  localparam int PLEN  = 48;
  localparam int XBITS = 5;
  localparam int PBITS = 6;

  typedef enum {K_RS_PHYS, K_RS_RDY, K_RD_PHYS, K_RD_OLD, K_ALLOC, K_FREE} kind_e;
  typedef struct {
    kind_e kind;
    int    idx;
    int    val;
    string tag;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb[$];
  int   exp_list[$];

  rename_if bus ();
  rename_unit dut (.i_clk(clk), .i_rst_n(rst_n), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input int exp_v);
    n_tests++;
    if (obs !== 32'(exp_v)) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic push(input kind_e kind, input int idx, input int val, input string tag);
    exp_t e;
    e.kind = kind; e.idx = idx; e.val = val; e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic drain_sb();
    exp_t e;
    logic [31:0] obs;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.kind)
        K_RS_PHYS: obs = 32'(bus.o_rs_phys[e.idx*PBITS +: PBITS]);
        K_RS_RDY:  obs = 32'(bus.o_rs_rdy[e.idx]);
        K_RD_PHYS: obs = 32'(bus.o_rd_phys[e.idx*PBITS +: PBITS]);
        K_RD_OLD:  obs = 32'(bus.o_rd_old[e.idx*PBITS +: PBITS]);
        K_ALLOC:   obs = 32'(bus.o_alloc_ready);
        default:   obs = 32'(bus.o_free_count);
      endcase
      check(e.tag, obs, e.val);
    end
  endtask

  task automatic idle();
    bus.i_dispatch  = 1'b0;
    bus.i_rs_arch   = '0;
    bus.i_rd_valid  = '0;
    bus.i_rd_arch   = '0;
    bus.i_wb_valid  = '0;
    bus.i_wb_phys   = '0;
    bus.i_cmt_valid = '0;
    bus.i_cmt_arch  = '0;
    bus.i_cmt_phys  = '0;
    bus.i_cmt_old   = '0;
    bus.i_flush     = 1'b0;
  endtask

  task automatic set_rs(input int s, input int a);
    bus.i_rs_arch[s*XBITS +: XBITS] = XBITS'(a);
  endtask

  task automatic set_rd(input int k, input int a);
    bus.i_rd_valid[k] = 1'b1;
    bus.i_rd_arch[k*XBITS +: XBITS] = XBITS'(a);
  endtask

  task automatic set_wb(input int w, input int p);
    bus.i_wb_valid[w] = 1'b1;
    bus.i_wb_phys[w*PBITS +: PBITS] = PBITS'(p);
  endtask

  task automatic set_cmt(input int c, input int a, input int p, input int o);
    bus.i_cmt_valid[c] = 1'b1;
    bus.i_cmt_arch[c*XBITS +: XBITS] = XBITS'(a);
    bus.i_cmt_phys[c*PBITS +: PBITS] = PBITS'(p);
    bus.i_cmt_old[c*PBITS +: PBITS]  = PBITS'(o);
  endtask

  // Compare mid-cycle, then advance one edge and return inputs to idle
  task automatic step();
    @(negedge clk);
    drain_sb();
    @(posedge clk);
    #1;
    idle();
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Reset state and combinational rename without dispatch
    set_rs(0, 5); set_rd(0, 1); set_rd(1, 2);
    push(K_RS_PHYS, 0, 5,  "t1_x5_phys");
    push(K_RS_RDY,  0, 1,  "t1_x5_rdy");
    push(K_RS_PHYS, 1, 0,  "t1_x0_phys");
    push(K_RS_RDY,  1, 1,  "t1_x0_rdy");
    push(K_FREE,    0, 16, "t1_free");
    push(K_ALLOC,   0, 1,  "t1_alloc");
    push(K_RD_PHYS, 0, 32, "t1_rd0");
    push(K_RD_PHYS, 1, 33, "t1_rd1");
    push(K_RD_OLD,  0, 1,  "t1_old0");
    push(K_RD_OLD,  1, 2,  "t1_old1");
    step();

    // Same-dest pair with intra-group source bypass
    set_rs(0, 3); set_rd(0, 3); set_rs(2, 3); set_rd(1, 3); bus.i_dispatch = 1'b1;
    push(K_RS_PHYS, 0, 3,  "t2_s0_phys");
    push(K_RS_RDY,  0, 1,  "t2_s0_rdy");
    push(K_RD_PHYS, 0, 32, "t2_rd0");
    push(K_RD_OLD,  0, 3,  "t2_old0");
    push(K_RS_PHYS, 2, 32, "t2_byp_phys");
    push(K_RS_RDY,  2, 0,  "t2_byp_rdy");
    push(K_RD_PHYS, 1, 33, "t2_rd1");
    push(K_RD_OLD,  1, 32, "t2_old1");
    push(K_ALLOC,   0, 1,  "t2_alloc");
    step();
    set_rs(0, 3);
    push(K_RS_PHYS, 0, 33, "t2_map_x3");
    push(K_RS_RDY,  0, 0,  "t2_x3_notrdy");
    push(K_FREE,    0, 14, "t2_free");
    step();

    // Writeback bypass, then registered ready bit
    set_rs(0, 3); set_wb(0, 33); set_wb(1, 0);
    push(K_RS_PHYS, 0, 33, "t4_phys");
    push(K_RS_RDY,  0, 1,  "t4_wb_bypass");
    step();
    set_rs(0, 3);
    push(K_RS_RDY,  0, 1,  "t4_ready_set");
    step();

    // Commit frees p3 next cycle; p3 then allocated first
    set_cmt(0, 3, 32, 3);
    push(K_FREE, 0, 14, "t5_free_same_cycle");
    step();
    set_rd(0, 4); bus.i_dispatch = 1'b1;
    push(K_FREE,    0, 15, "t5_free_after");
    push(K_RD_PHYS, 0, 3,  "t5_lowest_p3");
    push(K_RD_OLD,  0, 4,  "t5_old");
    push(K_ALLOC,   0, 1,  "t5_alloc");
    step();
    set_rs(0, 4);
    push(K_FREE,    0, 14, "t5_free_post");
    push(K_RS_PHYS, 0, 3,  "t5_x4_phys");
    push(K_RS_RDY,  0, 0,  "t5_x4_rdy");
    step();

    // Flush with a same-cycle commit; dispatch suppressed
    bus.i_flush = 1'b1; set_cmt(0, 4, 3, 4);
    set_rd(0, 7); set_rd(1, 8); bus.i_dispatch = 1'b1;
    push(K_ALLOC, 0, 0, "t6_alloc_flush");
    step();
    set_rs(0, 3); set_rs(1, 4); set_rs(2, 7);
    push(K_RS_PHYS, 0, 32, "t6_x3");
    push(K_RS_RDY,  0, 1,  "t6_x3_rdy");
    push(K_RS_PHYS, 1, 3,  "t6_x4");
    push(K_RS_RDY,  1, 1,  "t6_x4_rdy");
    push(K_RS_PHYS, 2, 7,  "t6_x7");
    push(K_FREE,    0, 16, "t6_free");
    step();

    // Drain all 16 free regs, lowest-first: p4 then p33..p47
    exp_list.push_back(4);
    for (int p = 33; p < PLEN; p++) exp_list.push_back(p);
    for (int i = 0; i < 8; i++) begin
      set_rd(0, 10); set_rd(1, 11); bus.i_dispatch = 1'b1;
      push(K_ALLOC,   0, 1,                             "t3_alloc");
      push(K_FREE,    0, 16 - 2*i,                      "t3_free");
      push(K_RD_PHYS, 0, exp_list[2*i],                 "t3_rd0");
      push(K_RD_PHYS, 1, exp_list[2*i+1],               "t3_rd1");
      push(K_RD_OLD,  0, (i == 0) ? 10 : exp_list[2*i-2], "t3_old0");
      push(K_RD_OLD,  1, (i == 0) ? 11 : exp_list[2*i-1], "t3_old1");
      step();
    end
    set_rd(0, 5); bus.i_dispatch = 1'b1;
    push(K_ALLOC, 0, 0, "t3_empty_alloc");
    push(K_FREE,  0, 0, "t3_empty_free");
    step();
    set_rs(0, 5); set_rs(1, 10); set_rd(0, 0); set_rd(1, 0);
    push(K_RS_PHYS, 0, 5,  "t3_map_unchanged");
    push(K_RS_PHYS, 1, 46, "t3_x10");
    push(K_RS_RDY,  1, 0,  "t3_x10_rdy");
    push(K_FREE,    0, 0,  "t3_free_zero");
    push(K_ALLOC,   0, 1,  "t3_x0_alloc");
    push(K_RD_PHYS, 0, 0,  "t3_x0_rd");
    push(K_RD_OLD,  1, 0,  "t3_x0_old");
    step();

    // Mid-operation async reset
    rst_n = 1'b0;
    set_rs(0, 10);
    push(K_RS_PHYS, 0, 10, "rst_x10");
    push(K_RS_RDY,  0, 1,  "rst_x10_rdy");
    push(K_FREE,    0, 16, "rst_free");
    step();
    rst_n = 1'b1;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
